// File: rtl/lcd_cmd_sequencer_if.sv
// Byte bus between the LCD command sequencer, the SPI display master and the host byte port.
// master = sequencer side, slave = SPI master / host side.
interface lcd_cmd_sequencer_if;
  logic [7:0] spi_data_out;
  logic       dc_in;
  logic       spi_send;
  logic       spi_send_done;
  logic       host_valid;
  logic       host_dc;
  logic [7:0] host_byte;
  logic       host_ready;

  modport master (
    output spi_data_out, dc_in, spi_send, host_ready,
    input  spi_send_done, host_valid, host_dc, host_byte
  );

  modport slave (
    input  spi_data_out, dc_in, spi_send, host_ready,
    output spi_send_done, host_valid, host_dc, host_byte
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// LCD sequencer: panel reset pulse, fixed init table playback, then host bytes to the SPI master.
// Define LCD_SEQ_TIMEOUT_EN to add the handshake watchdog and sticky ERROR state.
//
// state      | meaning
// RST_LOW    | lcd_rst_n low for RST_LOW_MS
// RST_WAIT   | lcd_rst_n high, settle for RST_WAIT_MS
// FETCH      | decode init ROM entry at r_idx
// DELAY      | wait payload ms from the ROM entry
// SEND       | raise spi_send
// WAIT_DONE  | hold request until spi_send_done high
// WAIT_LOW   | request dropped, wait for spi_send_done low
// READY      | host_ready, accept one host byte
// ERROR      | watchdog fired, held until reset (macro build only)
module lcd_cmd_sequencer #(
  parameter int CLK_PER_MS  = 100000,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_WAIT_MS = 120,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  lcd_cmd_sequencer_if.master bus,
  output logic                lcd_rst_n,
  output logic                init_done,
  output logic                busy,
  output logic                err
);
  localparam int TICK_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(CLK_PER_MS - 1);
  localparam logic [15:0] RST_LOW_LOAD  = 16'(RST_LOW_MS);
  localparam logic [15:0] RST_WAIT_LOAD = 16'(RST_WAIT_MS);

  if (CLK_PER_MS < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("lcd_cmd_sequencer: CLK_PER_MS must be >= 1 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [3:0] {
    S_RST_LOW, S_RST_WAIT, S_FETCH, S_DELAY, S_SEND,
    S_WAIT_DONE, S_WAIT_LOW, S_READY
`ifdef LCD_SEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  localparam logic [1:0] T_CMD = 2'b00, T_DATA = 2'b01, T_DELAY = 2'b10;

  function automatic logic [9:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_entry = {2'b00, 8'h01};
      4'd1:    rom_entry = {2'b10, 8'd150};
      4'd2:    rom_entry = {2'b00, 8'h11};
      4'd3:    rom_entry = {2'b10, 8'd120};
      4'd4:    rom_entry = {2'b00, 8'h3A};
      4'd5:    rom_entry = {2'b01, 8'h05};
      4'd6:    rom_entry = {2'b00, 8'h29};
      default: rom_entry = {2'b11, 8'h00};
    endcase
  endfunction

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_idx;
  logic [7:0]          r_byte;
  logic                r_dc;
  logic                r_init_done;
  logic [TICK_W-1:0]   r_tick;
  logic [15:0]         r_ms;
  logic [9:0]          w_entry;
  logic [1:0]          w_type;
  logic [7:0]          w_payload;
  logic                w_time_up;
  logic                w_wd_exp;

  assign w_entry   = rom_entry(r_idx);
  assign w_type    = w_entry[9:8];
  assign w_payload = w_entry[7:0];
  // Ends on the last tick of the last ms; a zero load ends after one cycle.
  assign w_time_up = (r_ms == 16'd0) || ((r_ms == 16'd1) && (r_tick == '0));

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_wd <= '0;
    else if (w_state_nxt != r_state) r_wd <= WD_LOAD;
    else if (r_wd != '0)             r_wd <= r_wd - 1'b1;
  end

  assign w_wd_exp = (r_wd == '0);
  assign err      = (r_state == S_ERROR);
`else
  assign w_wd_exp = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RST_LOW;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RST_LOW:  if (w_time_up) w_state_nxt = S_RST_WAIT;
      S_RST_WAIT: if (w_time_up) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_type == T_CMD || w_type == T_DATA) w_state_nxt = S_SEND;
        else if (w_type == T_DELAY)              w_state_nxt = S_DELAY;
        else                                     w_state_nxt = S_READY;
      end
      S_DELAY:    if (w_time_up) w_state_nxt = S_FETCH;
      S_SEND:     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
`ifdef LCD_SEQ_TIMEOUT_EN
        if (w_wd_exp) w_state_nxt = S_ERROR;
        else
`endif
        if (bus.spi_send_done) w_state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
`ifdef LCD_SEQ_TIMEOUT_EN
        if (w_wd_exp) w_state_nxt = S_ERROR;
        else
`endif
        if (!bus.spi_send_done) w_state_nxt = r_init_done ? S_READY : S_FETCH;
      end
      S_READY:    if (bus.host_valid) w_state_nxt = S_SEND;
      default:    w_state_nxt = r_state;
    endcase
  end

  // ms timer: sub-ms tick down-counter plus ms down-counter, reloaded on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= TICK_LOAD;
      r_ms   <= RST_LOW_LOAD;
    end else if (w_state_nxt != r_state) begin
      r_tick <= TICK_LOAD;
      if (w_state_nxt == S_RST_WAIT)   r_ms <= RST_WAIT_LOAD;
      else if (w_state_nxt == S_DELAY) r_ms <= {8'h00, w_payload};
    end else if (r_ms != 16'd0) begin
      if (r_tick == '0) begin
        r_tick <= TICK_LOAD;
        r_ms   <= r_ms - 16'd1;
      end else begin
        r_tick <= r_tick - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= 4'd0;
      r_byte      <= 8'h00;
      r_dc        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_type == T_CMD || w_type == T_DATA) begin
            r_byte <= w_payload;
            r_dc   <= w_type[0];
          end else if (w_type != T_DELAY) begin
            r_init_done <= 1'b1;
          end
        end
        S_DELAY:    if (w_time_up) r_idx <= r_idx + 4'd1;
        S_WAIT_LOW: if (!bus.spi_send_done && !r_init_done) r_idx <= r_idx + 4'd1;
        S_READY: begin
          if (bus.host_valid) begin
            r_byte <= bus.host_byte;
            r_dc   <= bus.host_dc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.spi_send     = (r_state == S_SEND) || (r_state == S_WAIT_DONE);
  assign bus.host_ready   = (r_state == S_READY);
  assign bus.spi_data_out = r_byte;
  assign bus.dc_in        = r_dc;
  assign lcd_rst_n        = (r_state != S_RST_LOW);
  assign busy             = (r_state != S_READY);
  assign init_done        = r_init_done;
endmodule
